jtag_scan_ctrl: RTL and testbench

- Host-side JTAG scan sequencer. Takes IR/DR scan requests over valid/ready, walks the TAP state machine by driving tms/tdi, captures tdo, and returns the captured bits over valid/ready.
- Sits between test sequences/register-access logic and the jtag_if master signals (tdi, tms, read_not_write, tdo).
- One scan in flight at a time.

---
 rtl/jtag_ctrl_pkg.sv | 30 +++
 rtl/jtag_shift_reg.sv | 64 ++++++
 rtl/jtag_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_jtag_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_ctrl_pkg.sv
// Shared types and constants for the JTAG scan sequencer.
// The request struct is sized for JTAG_MAX_LEN; the top's MAX_LEN should match it.
package jtag_ctrl_pkg;

  localparam int unsigned TLR_CYCLES   = 5;
  localparam int unsigned JTAG_MAX_LEN = 32;
  localparam int unsigned JTAG_LEN_W   = $clog2(JTAG_MAX_LEN + 1);

  typedef enum logic [3:0] {
    StResetSeq,
    StRti,
    StIdle,
    StSelDr,
    StSelIr,
    StCapture,
    StShift,
    StExit1,
    StUpdate,
    StWait,
    StResp
  } jtag_ctrl_state_e;

  typedef struct packed {
    logic                    is_ir;
    logic [JTAG_LEN_W-1:0]   len;
    logic [JTAG_MAX_LEN-1:0] data;
    logic                    rnw;
  } jtag_scan_req_t;

endpackage

// File: rtl/jtag_shift_reg.sv
// Scan data path: tdi shift-out register with bit counter, and a one-hot-mask
// capture register that assembles tdo bits LSB first.
module jtag_shift_reg
  import jtag_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN = JTAG_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] data_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               pop_i,
  output logic               bit_o,
  output logic [LEN_W-1:0]   bit_cnt_o,
  output logic               last_o,
  output logic               done_o,
  input  logic               capture_i,
  input  logic               tdo_i,
  output logic [MAX_LEN-1:0] cap_o
);

  logic [MAX_LEN-1:0] sr_q;
  logic [MAX_LEN-1:0] mask_q;
  logic [MAX_LEN-1:0] cap_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      if (load_i) begin
        sr_q  <= data_i;
        len_q <= len_i;
        cnt_q <= '0;
      end else if (pop_i) begin
        sr_q  <= sr_q >> 1;
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (clear_i) begin
        cap_q  <= '0;
        mask_q <= {{(MAX_LEN - 1){1'b0}}, 1'b1};
      end else if (capture_i) begin
        if (tdo_i) cap_q <= cap_q | mask_q;
        mask_q <= mask_q << 1;
      end
    end
  end

  // cnt_q counts bits already popped, so "last" means the next pop is the final bit.
  assign bit_o     = sr_q[0];
  assign bit_cnt_o = cnt_q;
  assign last_o    = (cnt_q == len_q - LEN_W'(1));
  assign done_o    = (cnt_q == len_q);
  assign cap_o     = cap_q;

endmodule

// File: rtl/jtag_scan_ctrl.sv
// Host-side JTAG scan sequencer: walks the TAP through IR/DR scans and returns tdo.
// Define JTAG_RTI_WAIT_EN to insert RTI_CYCLES Run-Test/Idle cycles after Update.
module jtag_scan_ctrl
  import jtag_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN    = JTAG_MAX_LEN,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1),
  parameter int unsigned RTI_CYCLES = 4
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_is_ir,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_data,
  input  logic               req_rnw,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               read_not_write,
  output logic               busy
);

`ifdef JTAG_RTI_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif
  localparam int unsigned CntW = 16;

  jtag_ctrl_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  jtag_scan_req_t   req_q, req_d;
  logic             tms_q, tms_d, tdi_q, tdi_d;
  logic             req_ready_q, rsp_valid_q, rsp_err_q, rsp_err_d;
  logic             rnw_q, rnw_d, busy_q;
  logic             accept, illegal;
  logic             sr_bit, sr_last, sr_done, sr_capture;
  logic [LEN_W-1:0] sr_cnt;

  assign illegal = (req_len == '0) || (req_len > LEN_W'(MAX_LEN));
  assign req_d   = '{is_ir: req_is_ir, len: req_len, data: req_data, rnw: req_rnw};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StResetSeq: begin
        if (cnt_q == CntW'(TLR_CYCLES - 1)) begin
          state_d = StRti;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRti:     state_d = StIdle;
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = illegal ? StResp : StSelDr;
        end
      end
      StSelDr:   state_d = req_q.is_ir ? StSelIr : StCapture;
      StSelIr:   state_d = StCapture;
      StCapture: state_d = StShift;
      StShift:   if (sr_done) state_d = StExit1;
      StExit1:   state_d = StUpdate;
      StUpdate: begin
        if (WaitEn && RTI_CYCLES != 0) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          state_d = StResp;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(RTI_CYCLES - 1)) state_d = StResp;
        else cnt_d = cnt_q + CntW'(1);
      end
      StResp:    if (rsp_ready) state_d = StIdle;
      default:   state_d = StResetSeq;
    endcase
  end

  // Outputs are decoded from the next state so the registered value lines up with it.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    rnw_d = 1'b0;
    unique case (state_d)
      StResetSeq, StSelIr, StExit1: tms_d = 1'b1;
      StSelDr:   tms_d = 1'b1;
      StShift: begin
        tms_d = sr_last;
        tdi_d = sr_bit;
      end
      default:   tms_d = 1'b0;
    endcase
    if (state_d inside {StSelDr, StSelIr, StCapture, StShift, StExit1, StUpdate}) begin
      rnw_d = (state_q == StIdle) ? req_rnw : req_q.rnw;
    end
    rsp_err_d = (state_d == StResp) && ((state_q == StIdle) || rsp_err_q);
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      state_q     <= StResetSeq;
      cnt_q       <= '0;
      req_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rnw_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      req_ready_q <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StResp);
      rsp_err_q   <= rsp_err_d;
      rnw_q       <= rnw_d;
      busy_q      <= (state_d != StIdle);
      if (accept) req_q <= req_d;
    end
  end

  // tdo of bit k is sampled while bit k+1 is on tdi; the final bit lands in Exit1.
  assign sr_capture = ((state_q == StShift) && (sr_cnt != LEN_W'(1))) || (state_q == StExit1);

  jtag_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift_reg (
    .clk_i     (tck),
    .rst_i     (trst),
    .clear_i   (accept),
    .load_i    (state_q == StSelDr),
    .data_i    (req_q.data),
    .len_i     (req_q.len),
    .pop_i     (state_d == StShift),
    .bit_o     (sr_bit),
    .bit_cnt_o (sr_cnt),
    .last_o    (sr_last),
    .done_o    (sr_done),
    .capture_i (sr_capture),
    .tdo_i     (tdo),
    .cap_o     (rsp_data)
  );

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign tms            = tms_q;
  assign tdi            = tdi_q;
  assign read_not_write = rnw_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Randomised bench for jtag_scan_ctrl against a cycle-sequence model of the TAP walk,
// with a one-cycle-latency TAP stand-in driving tdo.
module tb_jtag_scan_ctrl;

  localparam int unsigned MaxLen    = 32;
  localparam int unsigned LenW      = 6;
  localparam int unsigned RtiCycles = 4;
`ifdef JTAG_RTI_WAIT_EN
  localparam int unsigned WaitCycles = RtiCycles;
`else
  localparam int unsigned WaitCycles = 0;
`endif

  logic              tck = 1'b0;
  logic              trst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_is_ir = 1'b0;
  logic [LenW-1:0]   req_len = '0;
  logic [MaxLen-1:0] req_data = '0;
  logic              req_rnw = 1'b0;
  logic              rsp_ready = 1'b0;
  logic              tdo = 1'b0;
  logic              req_ready, rsp_valid, rsp_err, tms, tdi, read_not_write, busy;
  logic [MaxLen-1:0] rsp_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          tdo_mode = 0;

  jtag_scan_ctrl #(
    .MAX_LEN    (MaxLen),
    .LEN_W      (LenW),
    .RTI_CYCLES (RtiCycles)
  ) dut (
    .tck            (tck),
    .trst           (trst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_ir      (req_is_ir),
    .req_len        (req_len),
    .req_data       (req_data),
    .req_rnw        (req_rnw),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .read_not_write (read_not_write),
    .busy           (busy)
  );

  always #5 tck = ~tck;

  // TAP stand-in: tdo reflects the bit shifted in on the previous edge.
  always @(posedge tck) begin
    case (tdo_mode)
      0:       tdo <= tdi;
      1:       tdo <= ~tdi;
      2:       tdo <= 1'b1;
      default: tdo <= 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset(input int cycles);
    logic [6:0] tms_seq, rdy_seq;
    logic       any_valid;
    @(negedge tck);
    trst      = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (cycles) @(negedge tck);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_rnw", read_not_write, 0);
    check("rst_busy", busy, 1);
    trst      = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge tck);
      tms_seq[i] = tms;
      rdy_seq[i] = req_ready;
      any_valid  = any_valid | rsp_valid;
    end
    check("rst_tms_seq", tms_seq, 7'b0011111);
    check("rst_ready_seq", rdy_seq, 7'b1000000);
    check("rst_no_rsp", any_valid, 0);
  endtask

  // Entered and left on a negedge.
  task automatic run_scan(input logic is_ir, input logic [LenW-1:0] len,
                          input logic [MaxLen-1:0] data, input logic rnw,
                          input int mode, input int hold);
    logic [63:0]       got_tms, got_tdi, got_rnw, exp_tms, exp_tdi, exp_rnw;
    logic [MaxLen-1:0] exp_data, held_data;
    logic              legal, busy_all, stable;
    int                n, en, waited;

    // Model: the expected per-cycle TAP walk from SEL_DR until the response appears.
    legal   = (len >= 1) && (len <= MaxLen);
    en      = 0;
    exp_tms = '0;
    exp_tdi = '0;
    exp_rnw = '0;
    exp_data = '0;
    if (legal) begin
      exp_tms[en] = 1'b1; exp_rnw[en] = rnw; en++;
      if (is_ir) begin
        exp_tms[en] = 1'b1; exp_rnw[en] = rnw; en++;
      end
      exp_rnw[en] = rnw; en++;
      for (int k = 0; k < int'(len); k++) begin
        exp_tms[en] = (k == int'(len) - 1);
        exp_tdi[en] = data[k];
        exp_rnw[en] = rnw;
        en++;
        case (mode)
          0:       exp_data[k] = data[k];
          1:       exp_data[k] = ~data[k];
          2:       exp_data[k] = 1'b1;
          default: exp_data[k] = 1'b0;
        endcase
      end
      exp_tms[en] = 1'b1; exp_rnw[en] = rnw; en++;
      exp_rnw[en] = rnw; en++;
      en += WaitCycles;
    end

    tdo_mode  = mode;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_is_ir = is_ir;
    req_len   = len;
    req_data  = data;
    req_rnw   = rnw;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge tck);
      waited++;
    end
    check("req_accept", req_ready, 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge tck);
    req_valid = 1'b0;

    n        = 0;
    busy_all = 1'b1;
    got_tms  = '0;
    got_tdi  = '0;
    got_rnw  = '0;
    while (!rsp_valid && n < 100) begin
      if (n < 64) begin
        got_tms[n] = tms;
        got_tdi[n] = tdi;
        got_rnw[n] = read_not_write;
      end
      busy_all = busy_all & busy;
      n++;
      @(negedge tck);
    end
    check("rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    check("seq_len", n, en);
    check("tms_seq", got_tms, exp_tms);
    check("tdi_seq", got_tdi, exp_tdi);
    check("rnw_seq", got_rnw, exp_rnw);
    check("busy_scan", busy_all, 1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, !legal);
    check("rsp_tms", tms, 0);
    check("rsp_rnw", read_not_write, 0);
    check("rsp_req_ready", req_ready, 0);

    held_data = rsp_data;
    stable    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge tck);
      stable = stable & rsp_valid & (rsp_data == held_data) & !req_ready & (rsp_err == !legal);
    end
    if (hold > 0) check("rsp_hold", stable, 1);

    rsp_ready = 1'b1;
    @(negedge tck);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic abort_scan();
    int waited;
    tdo_mode  = 0;
    req_valid = 1'b1;
    req_is_ir = 1'b0;
    req_len   = LenW'(20);
    req_data  = $urandom;
    req_rnw   = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge tck);
      waited++;
    end
    check("abort_accept", req_ready, 1);
    @(negedge tck);
    req_valid = 1'b0;
    repeat (5) @(negedge tck);
    check("abort_mid_shift_tms", tms, 0);
    check("abort_mid_shift_rnw", read_not_write, 1);
    apply_reset(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LenW-1:0] len;
    apply_reset(2);
    run_scan(1'b0, LenW'(8), MaxLen'('hA5), 1'b1, 0, 0);
    run_scan(1'b1, LenW'(4), MaxLen'('h3), 1'b0, 2, 0);
    run_scan(1'b0, LenW'(0), MaxLen'('h5A), 1'b0, 2, 0);
    run_scan(1'b0, LenW'(33), MaxLen'('hFFFF), 1'b1, 2, 0);
    run_scan(1'b0, LenW'(1), MaxLen'('h1), 1'b1, 0, 0);
    run_scan(1'b1, LenW'(32), MaxLen'($urandom), 1'b1, 1, 0);
    run_scan(1'b0, LenW'(16), MaxLen'('h1234), 1'b0, 0, 10);
    abort_scan();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1) ? LenW'(0) : LenW'($urandom_range(33, 63));
      else len = LenW'($urandom_range(1, 32));
      run_scan(1'($urandom_range(0, 1)), len, MaxLen'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
